// File: rtl/cache_ctrl_pkg.sv
// Shared sizes and FSM encoding for the cache request sequencer.
// Address split: tag [31:7], set index [6:3], byte offset [2:0].
package cache_ctrl_pkg;

    localparam int ADDR_W   = 32;
    localparam int INDEX_W  = 4;
    localparam int OFFSET_W = 3;
    localparam int NUM_SETS = 1 << INDEX_W;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int DATA_W   = 64;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEARCH = 3'd1,
        S_EVAL   = 3'd2,
        S_FETCH  = 3'd3,
        S_UPDATE = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    function automatic logic [NUM_SETS-1:0] onehot(
        input logic [INDEX_W-1:0] idx
    );
        logic [NUM_SETS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU-side request/response handshake of the cache sequencer.
interface cache_ctrl_if;
    import cache_ctrl_pkg::*;

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_hit;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output req_valid, req_addr,
        input  req_ready, resp_valid, resp_hit, resp_data
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, resp_valid, resp_hit, resp_data
    );

endinterface

// File: rtl/cache_ctrl_addr_decode.sv
// Combinational tag/index split of a byte address plus one-hot set select.
module cache_ctrl_addr_decode
    import cache_ctrl_pkg::*;
(
    input  logic [ADDR_W-1:0]   addr,
    output logic [TAG_W-1:0]    tag,
    output logic [INDEX_W-1:0]  index,
    output logic [NUM_SETS-1:0] sel
);

    // Offset selects a byte within the line; the sets never see it.
    logic [OFFSET_W-1:0] unused_offset;

    assign tag           = addr[ADDR_W-1 -: TAG_W];
    assign index         = addr[OFFSET_W +: INDEX_W];
    assign unused_offset = addr[OFFSET_W-1:0];
    assign sel           = onehot(index);

endmodule

// File: rtl/cache_ctrl.sv
// Request sequencer between the CPU and the FIFO-replacement set array.
// Optional CACHE_CTRL_STATS_EN adds saturating hit/miss counters.
module cache_ctrl
    import cache_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    cache_ctrl_if.slave                cpu,
    output logic                       set_state,
    output logic [NUM_SETS-1:0]        set_enable,
    output logic [TAG_W-1:0]           set_tag,
    output logic [DATA_W-1:0]          set_write_data,
    output logic                       set_mem_write,
    input  logic [NUM_SETS-1:0]        set_hit,
    input  logic [NUM_SETS*DATA_W-1:0] set_read_data,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_ack,
    input  logic [DATA_W-1:0]          mem_data
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]                stat_hits,
    output logic [31:0]                stat_misses
`endif
);

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   fill_q;
    logic                hit_q;
    logic                ready_q;
    logic                resp_q;
    logic                en_q;
    logic [INDEX_W-1:0]  index;
    logic [NUM_SETS-1:0] sel;
    logic [DATA_W-1:0]   sel_data;

    // Everything the sets see comes from the latched address.
    cache_ctrl_addr_decode u_decode (
        .addr  (addr_q),
        .tag   (set_tag),
        .index (index),
        .sel   (sel)
    );

    assign sel_data       = set_read_data[index * DATA_W +: DATA_W];
    assign set_enable     = en_q ? sel : '0;
    assign set_write_data = fill_q;
    assign mem_addr       = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

    assign cpu.req_ready  = ready_q;
    assign cpu.resp_valid = resp_q;
    assign cpu.resp_hit   = hit_q;
    assign cpu.resp_data  = fill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            addr_q        <= '0;
            fill_q        <= '0;
            hit_q         <= 1'b0;
            ready_q       <= 1'b1;
            resp_q        <= 1'b0;
            en_q          <= 1'b0;
            set_state     <= 1'b0;
            set_mem_write <= 1'b0;
            mem_req       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cpu.req_valid) begin
                        addr_q  <= cpu.req_addr;
                        ready_q <= 1'b0;
                        en_q    <= 1'b1;
                        state   <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    en_q  <= 1'b0;
                    state <= S_EVAL;
                end
                S_EVAL: begin
                    hit_q <= set_hit[index];
                    if (set_hit[index]) begin
                        fill_q    <= sel_data;
                        set_state <= 1'b1;
                        en_q      <= 1'b1;
                        state     <= S_UPDATE;
                    end else begin
                        mem_req <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        fill_q        <= mem_data;
                        mem_req       <= 1'b0;
                        set_state     <= 1'b1;
                        set_mem_write <= 1'b1;
                        en_q          <= 1'b1;
                        state         <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    set_state     <= 1'b0;
                    set_mem_write <= 1'b0;
                    en_q          <= 1'b0;
                    resp_q        <= 1'b1;
                    state         <= S_RESP;
                end
                S_RESP: begin
                    resp_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (state == S_RESP) begin
            if (hit_q && stat_hits != 32'hFFFF_FFFF)
                stat_hits <= stat_hits + 32'd1;
            if (!hit_q && stat_misses != 32'hFFFF_FFFF)
                stat_misses <= stat_misses + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: plays the set array and backing memory.
module tb_cache_ctrl;
    import cache_ctrl_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          set_state;
    logic [15:0]   set_enable;
    logic [24:0]   set_tag;
    logic [63:0]   set_write_data;
    logic          set_mem_write;
    logic [15:0]   set_hit = '0;
    logic [1023:0] set_read_data = '0;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack = 1'b0;
    logic [63:0]   mem_data = '0;
`ifdef CACHE_CTRL_STATS_EN
    logic [31:0]   stat_hits;
    logic [31:0]   stat_misses;
`endif

    always #5 clk = ~clk;

    cache_ctrl_if cpu ();

    cache_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu            (cpu),
        .set_state      (set_state),
        .set_enable     (set_enable),
        .set_tag        (set_tag),
        .set_write_data (set_write_data),
        .set_mem_write  (set_mem_write),
        .set_hit        (set_hit),
        .set_read_data  (set_read_data),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_data       (mem_data)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .stat_hits      (stat_hits),
        .stat_misses    (stat_misses)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference contents of the set array, keyed by line address addr[31:3].
    logic [63:0] lines [logic [28:0]];

    int   mem_wait = 0;
    int   ack_cnt = 0;
    logic force_ack = 1'b0;
    logic iso_mode = 1'b0;

    // Memory answers after mem_wait idle FETCH cycles.
    always @(negedge clk) begin
        if (!mem_req) begin
            ack_cnt = 0;
            mem_ack = force_ack;
        end else begin
            ack_cnt = ack_cnt + 1;
            mem_ack = (ack_cnt == mem_wait + 1);
        end
    end

    // Set array: answers a search with noise on every set except the selected one.
    always @(negedge clk) begin
        int          idx;
        logic [28:0] key;
        logic [31:0] r;
        if (!set_state && set_enable != 16'd0) begin
            idx = $clog2(set_enable);
            key = {set_tag, idx[3:0]};
            r = $urandom;
            set_hit = r[15:0];
            for (int k = 0; k < 16; k++)
                set_read_data[k*64 +: 64] = {$urandom, $urandom};
            set_hit[idx] = lines.exists(key);
            if (lines.exists(key))
                set_read_data[idx*64 +: 64] = lines[key];
            if (iso_mode)
                set_hit = 16'hFF7F;
        end
    end

    int          lat, mem_cycles, srch_n, upd_n, st1_n, acc_wait;
    logic        got_resp, o_hit, pulse_ok, ready_bad, multihot, ready_after;
    logic [31:0] o_mem_addr;
    logic [15:0] o_upd_en;
    logic [24:0] o_upd_tag;
    logic        o_upd_mw;
    logic [63:0] o_data, o_upd_wd;

    // Runs one transaction and records what the DUT did; starts and ends at a negedge.
    task automatic do_req(input logic [31:0] addr, input int wait_c,
                          input logic [63:0] fdata, input bit hold);
        bit accepted;
        mem_wait = wait_c;
        mem_data = fdata;
        cpu.req_valid = 1'b1;
        cpu.req_addr = addr;
        lat = 0; mem_cycles = 0; srch_n = 0; upd_n = 0; st1_n = 0;
        acc_wait = 0; got_resp = 0; o_hit = 0; pulse_ok = 0;
        ready_bad = 0; multihot = 0; ready_after = 0;
        o_mem_addr = '0; o_upd_en = '0; o_upd_tag = '0;
        o_upd_mw = 0; o_data = '0; o_upd_wd = '0;
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            if (cpu.req_ready) begin
                @(posedge clk);
                accepted = 1;
                break;
            end
            acc_wait++;
            @(negedge clk);
        end
        if (!accepted) return;
        #1;
        if (!hold) begin
            cpu.req_valid = 1'b0;
            cpu.req_addr = $urandom;
        end
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (cpu.req_ready) ready_bad = 1;
            if ((set_enable & (set_enable - 16'd1)) != 16'd0) multihot = 1;
            if (set_enable != 16'd0 && !set_state) srch_n++;
            if (set_state) begin
                st1_n++;
                if (set_enable != 16'd0) begin
                    upd_n++;
                    o_upd_en = set_enable;
                    o_upd_tag = set_tag;
                    o_upd_mw = set_mem_write;
                    o_upd_wd = set_write_data;
                end
            end
            if (mem_req) begin
                mem_cycles++;
                o_mem_addr = mem_addr;
            end
            if (cpu.resp_valid) begin
                got_resp = 1;
                lat = k;
                o_hit = cpu.resp_hit;
                o_data = cpu.resp_data;
                break;
            end
        end
        if (got_resp) begin
            @(negedge clk);
            pulse_ok = !cpu.resp_valid;
            ready_after = cpu.req_ready;
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (cpu.req_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready got %b want 1", cpu.req_ready); end
        checks++; if (cpu.resp_valid !== 1'b0) begin errors++;
            $display("FAIL reset_resp_valid got %b want 0", cpu.resp_valid); end
        checks++; if (mem_req !== 1'b0) begin errors++;
            $display("FAIL reset_mem_req got %b want 0", mem_req); end
        checks++; if ({set_state, set_mem_write, set_enable} !== 18'd0) begin errors++;
            $display("FAIL reset_set_ctl got %h want 0", {set_state, set_mem_write, set_enable}); end
        checks++; if ({set_tag, mem_addr, cpu.resp_data, set_write_data} !== '0) begin errors++;
            $display("FAIL reset_data got nonzero want 0"); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cpu.req_ready !== 1'b1) begin errors++;
            $display("FAIL post_reset_ready got %b want 1", cpu.req_ready); end
    endtask

    task automatic test_cold_miss();
        do_req(32'h0000_1238, 2, 64'hDEAD_BEEF_0123_4567, 0);
        lines[29'(32'h0000_1238 >> 3)] = 64'hDEAD_BEEF_0123_4567;
        checks++; if (got_resp !== 1'b1 || lat != 7) begin errors++;
            $display("FAIL cold_latency got %0d want 7 (resp %b)", lat, got_resp); end
        checks++; if (o_mem_addr !== 32'h0000_1238 || mem_cycles != 3) begin errors++;
            $display("FAIL cold_mem_addr got %h/%0d want 00001238/3", o_mem_addr, mem_cycles); end
        checks++; if (o_upd_en !== 16'h0080 || o_upd_tag !== 25'h24) begin errors++;
            $display("FAIL cold_update_sel got %h/%h want 0080/24", o_upd_en, o_upd_tag); end
        checks++; if (o_upd_mw !== 1'b1 || o_upd_wd !== 64'hDEAD_BEEF_0123_4567) begin errors++;
            $display("FAIL cold_fill got %b/%h want 1/deadbeef01234567", o_upd_mw, o_upd_wd); end
        checks++; if (o_hit !== 1'b0 || o_data !== 64'hDEAD_BEEF_0123_4567) begin errors++;
            $display("FAIL cold_resp got %b/%h want 0/deadbeef01234567", o_hit, o_data); end
        checks++; if (!pulse_ok || srch_n != 1 || upd_n != 1 || st1_n != 1 || multihot) begin errors++;
            $display("FAIL cold_phases got pulse %b srch %0d upd %0d st1 %0d mh %b want 1/1/1/1/0",
                     pulse_ok, srch_n, upd_n, st1_n, multihot); end
    endtask

    task automatic test_repeat_hit();
        do_req(32'h0000_1238, 2, 64'h1111_2222_3333_4444, 0);
        checks++; if (got_resp !== 1'b1 || lat != 4) begin errors++;
            $display("FAIL hit_latency got %0d want 4 (resp %b)", lat, got_resp); end
        checks++; if (mem_cycles != 0) begin errors++;
            $display("FAIL hit_no_mem got %0d mem_req cycles want 0", mem_cycles); end
        checks++; if (o_upd_mw !== 1'b0 || o_upd_en !== 16'h0080 || upd_n != 1) begin errors++;
            $display("FAIL hit_update got mw %b en %h n %0d want 0/0080/1", o_upd_mw, o_upd_en, upd_n); end
        checks++; if (o_hit !== 1'b1 || o_data !== 64'hDEAD_BEEF_0123_4567) begin errors++;
            $display("FAIL hit_resp got %b/%h want 1/deadbeef01234567", o_hit, o_data); end
    endtask

    task automatic test_index_isolation();
        logic [63:0] f;
        f = {$urandom, $urandom};
        iso_mode = 1'b1;
        do_req(32'h0000_A0B8, 0, f, 0);
        iso_mode = 1'b0;
        lines[29'(32'h0000_A0B8 >> 3)] = f;
        checks++; if (got_resp !== 1'b1 || o_hit !== 1'b0 || lat != 5 || mem_cycles != 1) begin errors++;
            $display("FAIL isolation got hit %b lat %0d mem %0d want 0/5/1", o_hit, lat, mem_cycles); end
        checks++; if (o_data !== f) begin errors++;
            $display("FAIL isolation_data got %h want %h", o_data, f); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] f;
        f = {$urandom, $urandom};
        do_req(32'h0000_5A10, 1, f, 1);
        lines[29'(32'h0000_5A10 >> 3)] = f;
        checks++; if (got_resp !== 1'b1 || lat != 6 || ready_bad) begin errors++;
            $display("FAIL bp_first got lat %0d ready_bad %b want 6/0", lat, ready_bad); end
        checks++; if (ready_after !== 1'b1) begin errors++;
            $display("FAIL bp_idle_ready got %b want 1", ready_after); end
        do_req(32'h0000_5A10, 1, 64'h0, 0);
        checks++; if (acc_wait != 0 || lat != 4 || o_hit !== 1'b1 || o_data !== f) begin errors++;
            $display("FAIL bp_second got wait %0d lat %0d hit %b data %h want 0/4/1/%h",
                     acc_wait, lat, o_hit, o_data, f); end
    endtask

    task automatic test_async_reset();
        bit seen, bad;
        logic [63:0] f;
        seen = 0; bad = 0;
        mem_wait = 30;
        cpu.req_valid = 1'b1;
        cpu.req_addr = 32'h0000_3F00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) begin seen = 1; break; end
        end
        cpu.req_valid = 1'b0;
        checks++; if (!seen) begin errors++;
            $display("FAIL arst_fetch got no mem_req want 1"); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || cpu.req_ready !== 1'b1 || cpu.resp_valid !== 1'b0) begin errors++;
            $display("FAIL arst_immediate got req %b ready %b resp %b want 0/1/0",
                     mem_req, cpu.req_ready, cpu.resp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        force_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_req || cpu.resp_valid || !cpu.req_ready || set_enable != 16'd0) bad = 1;
        end
        force_ack = 1'b0;
        @(negedge clk);
        checks++; if (bad) begin errors++;
            $display("FAIL arst_late_ack got activity want idle"); end
        f = {$urandom, $urandom};
        do_req(32'h0000_3F00, 0, f, 0);
        lines[29'(32'h0000_3F00 >> 3)] = f;
        checks++; if (got_resp !== 1'b1 || o_hit !== 1'b0 || lat != 5 || o_data !== f) begin errors++;
            $display("FAIL arst_retry got hit %b lat %0d data %h want 0/5/%h", o_hit, lat, o_data, f); end
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        logic [31:0] a;
        logic [28:0] key;
        logic [63:0] f, exp_d;
        logic [15:0] exp_en;
        bit          exp_hit;
        int          w, exp_lat;
        for (int i = 0; i < 8; i++) pool[i] = $urandom;
        for (int n = 0; n < 40; n++) begin
            a = pool[$urandom_range(7)];
            a[2:0] = 3'($urandom);
            w = $urandom_range(3);
            f = {$urandom, $urandom};
            key = a[31:3];
            exp_hit = lines.exists(key);
            exp_d = exp_hit ? lines[key] : f;
            exp_lat = exp_hit ? 4 : 5 + w;
            exp_en = 16'd1 << ((a / 8) % 16);
            do_req(a, w, f, 0);
            if (!exp_hit) lines[key] = f;
            checks++; if (got_resp !== 1'b1 || o_hit !== exp_hit || o_data !== exp_d) begin errors++;
                $display("FAIL rand_resp addr %h got %b/%h want %b/%h", a, o_hit, o_data, exp_hit, exp_d); end
            checks++; if (lat != exp_lat || mem_cycles != (exp_hit ? 0 : w + 1)) begin errors++;
                $display("FAIL rand_latency addr %h got %0d/%0d want %0d/%0d",
                         a, lat, mem_cycles, exp_lat, exp_hit ? 0 : w + 1); end
            checks++; if (!exp_hit && o_mem_addr !== {a[31:3], 3'b000}) begin errors++;
                $display("FAIL rand_mem_addr got %h want %h", o_mem_addr, {a[31:3], 3'b000}); end
            checks++; if (o_upd_en !== exp_en || o_upd_tag !== 25'(a / 128)
                          || o_upd_mw !== !exp_hit || o_upd_wd !== exp_d) begin errors++;
                $display("FAIL rand_update addr %h got %h/%h/%b/%h want %h/%h/%b/%h", a,
                         o_upd_en, o_upd_tag, o_upd_mw, o_upd_wd, exp_en, 25'(a / 128), !exp_hit, exp_d); end
            checks++; if (!pulse_ok || ready_bad || multihot || srch_n != 1 || upd_n != 1 || st1_n != 1) begin errors++;
                $display("FAIL rand_protocol got pulse %b rb %b mh %b s %0d u %0d st %0d want 1/0/0/1/1/1",
                         pulse_ok, ready_bad, multihot, srch_n, upd_n, st1_n); end
        end
    endtask

`ifdef CACHE_CTRL_STATS_EN
    task automatic test_stats();
        logic [31:0] a [3];
        pulse_reset();
        checks++; if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin errors++;
            $display("FAIL stats_reset got %0d/%0d want 0/0", stat_hits, stat_misses); end
        for (int i = 0; i < 3; i++) begin
            a[i] = 32'hC000_0000 + 32'(i * 8);
            do_req(a[i], 0, {$urandom, $urandom}, 0);
            lines[a[i][31:3]] = mem_data;
        end
        for (int i = 0; i < 5; i++) do_req(a[i % 3], 0, 64'h0, 0);
        @(negedge clk);
        checks++; if (stat_hits !== 32'd5 || stat_misses !== 32'd3) begin errors++;
            $display("FAIL stats_count got %0d/%0d want 5/3", stat_hits, stat_misses); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu.req_valid = 1'b0;
        cpu.req_addr = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_cold_miss();
        test_repeat_hit();
        test_index_isolation();
        test_back_to_back();
        test_async_reset();
        test_random();
`ifdef CACHE_CTRL_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
